// File: rtl/blk_chk_pkg.sv
// Shared types and constants for the begin/end nesting checker and its arbiter.
// Optional stall watchdog in the arbiter is enabled with CHK_TIMEOUT_EN.
package blk_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_REPORT
    } arb_state_t;

    localparam logic [7:0]  ASCII_SPACE  = 8'h20;
    localparam logic [7:0]  FOLD_MASK    = 8'h20;
    localparam logic [39:0] KW_BEGIN     = "begin";
    localparam logic [23:0] KW_END       = "end";
    localparam int          MAX_WORD_LEN = 6;
    localparam int          WORD_LEN_W   = 3;

    // Lower-case letters; a space is unchanged by the fold.
    function automatic logic [7:0] fold_char(input logic [7:0] c);
        return c | FOLD_MASK;
    endfunction

endpackage

// File: rtl/blk_depth_core.sv
// Word buffer plus saturating depth counter: "begin" nests one level, "end" unnests.
// Words are delimited by spaces or by the last char of a packet.
module blk_depth_core
    import blk_chk_pkg::*;
#(
    parameter int DEPTH_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      ch_valid,
    input  logic [7:0]                ch,
    input  logic                      ch_last,
    output logic signed [DEPTH_W-1:0] depth,
    output logic                      underflow,
    output logic                      overflow
);

    localparam logic signed [DEPTH_W-1:0] DEPTH_MAX = {1'b0, {(DEPTH_W-1){1'b1}}};
    localparam logic signed [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    logic [39:0]           word_reg;
    logic [WORD_LEN_W-1:0] len_reg;

    logic [7:0]            ch_f;
    logic                  is_space;
    logic [39:0]           word_app;
    logic [39:0]           eval_word;
    logic [WORD_LEN_W-1:0] len_app;
    logic [WORD_LEN_W-1:0] eval_len;
    logic                  word_done;
    logic                  is_begin;
    logic                  is_end;

    // The newest char enters at the low byte, so the buffer reads like a string literal.
    always_comb begin
        ch_f      = fold_char(ch);
        is_space  = (ch_f == ASCII_SPACE);
        word_app  = {word_reg[31:0], ch_f};
        len_app   = (len_reg == WORD_LEN_W'(MAX_WORD_LEN)) ? len_reg : len_reg + 1'b1;
        eval_word = is_space ? word_reg : word_app;
        eval_len  = is_space ? len_reg  : len_app;
        word_done = ch_valid && (is_space || ch_last);
        is_begin  = word_done && (eval_len == WORD_LEN_W'(5)) && (eval_word == KW_BEGIN);
        is_end    = word_done && (eval_len == WORD_LEN_W'(3)) && (eval_word[23:0] == KW_END);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            word_reg  <= '0;
            len_reg   <= '0;
            depth     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else if (ch_valid) begin
            if (word_done) begin
                word_reg <= '0;
                len_reg  <= '0;
            end else begin
                word_reg <= word_app;
                len_reg  <= len_app;
            end
            if (is_begin) begin
                if (depth == DEPTH_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    depth <= depth + DEPTH_ONE;
                end
            end else if (is_end) begin
                if (depth == '0) begin
                    underflow <= 1'b1;
                end else begin
                    depth <= depth - DEPTH_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/blk_check_arbiter.sv
// Round-robin packet arbiter sharing one blk_depth_core among N_SRC char streams.
// Define CHK_TIMEOUT_EN to abort a packet after TIMEOUT stalled cycles in STREAM.
module blk_check_arbiter
    import blk_chk_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int DEPTH_W = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [8*N_SRC-1:0]       src_data,
    input  logic [N_SRC-1:0]         src_last,
    output logic                     rpt_valid,
    output logic [$clog2(N_SRC)-1:0] rpt_src,
    output logic                     rpt_ok,
    output logic [DEPTH_W-1:0]       rpt_depth,
    output logic                     rpt_timeout,
    output logic                     busy
);

    localparam int SRC_W = $clog2(N_SRC);

    if (N_SRC < 2 || N_SRC > 8 || TIMEOUT < 1) begin : g_param_check
        $error("blk_check_arbiter: N_SRC must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_t       state_reg;
    logic [SRC_W-1:0] grant_reg;
    logic [SRC_W-1:0] rr_ptr_reg;
    logic             rpt_valid_reg;
    logic [SRC_W-1:0] rpt_src_reg;
    logic             tmo_flag;

    logic [SRC_W-1:0] pick_idx;
    logic [SRC_W-1:0] cand;
    logic             found;
    logic [SRC_W-1:0] rr_ptr_next;
    logic             hs;
    logic [7:0]       src_ch [N_SRC];

    logic signed [DEPTH_W-1:0] core_depth;
    logic                      core_underflow;
    logic                      core_overflow;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign src_ch[gi]    = src_data[8*gi+7:8*gi];
        assign src_ready[gi] = (state_reg == ST_STREAM) && (grant_reg == SRC_W'(gi));
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_idx = rr_ptr_reg;
        cand     = '0;
        found    = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = SRC_W'((int'(rr_ptr_reg) + i) % N_SRC);
            if (!found && src_valid[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign rr_ptr_next = (grant_reg == SRC_W'(N_SRC - 1)) ? '0 : grant_reg + 1'b1;
    assign hs          = (state_reg == ST_STREAM) && src_valid[grant_reg];

`ifdef CHK_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt_reg;
    logic               rpt_timeout_reg;
    assign tmo_flag = rpt_timeout_reg;
`else
    assign tmo_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            rpt_valid_reg <= 1'b0;
            rpt_src_reg   <= '0;
`ifdef CHK_TIMEOUT_EN
            stall_cnt_reg   <= '0;
            rpt_timeout_reg <= 1'b0;
`endif
        end else begin
            rpt_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|src_valid) begin
                        grant_reg <= pick_idx;
                        state_reg <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_reg <= ST_STREAM;
`ifdef CHK_TIMEOUT_EN
                    stall_cnt_reg <= '0;
`endif
                end
                ST_STREAM: begin
                    if (hs && src_last[grant_reg]) begin
                        state_reg     <= ST_REPORT;
                        rpt_valid_reg <= 1'b1;
                        rpt_src_reg   <= grant_reg;
                    end
`ifdef CHK_TIMEOUT_EN
                    if (hs) begin
                        stall_cnt_reg <= '0;
                    end else if (stall_cnt_reg == STALL_W'(TIMEOUT - 1)) begin
                        state_reg       <= ST_REPORT;
                        rpt_valid_reg   <= 1'b1;
                        rpt_src_reg     <= grant_reg;
                        rpt_timeout_reg <= 1'b1;
                    end else begin
                        stall_cnt_reg <= stall_cnt_reg + 1'b1;
                    end
`endif
                end
                ST_REPORT: begin
                    rr_ptr_reg <= rr_ptr_next;
                    state_reg  <= ST_IDLE;
`ifdef CHK_TIMEOUT_EN
                    rpt_timeout_reg <= 1'b0;
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    blk_depth_core #(
        .DEPTH_W(DEPTH_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_reg == ST_CLEAR),
        .ch_valid (hs),
        .ch       (src_ch[grant_reg]),
        .ch_last  (src_last[grant_reg]),
        .depth    (core_depth),
        .underflow(core_underflow),
        .overflow (core_overflow)
    );

    // The core already holds the final char's effect by the time REPORT is entered.
    assign rpt_valid   = rpt_valid_reg;
    assign rpt_src     = rpt_src_reg;
    assign rpt_timeout = rpt_valid_reg & tmo_flag;
    assign rpt_ok      = rpt_valid_reg & ~tmo_flag & (core_depth == '0)
                         & ~core_underflow & ~core_overflow;
    assign rpt_depth   = rpt_valid_reg ? core_depth : '0;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_blk_check_arbiter.sv
// Scoreboard bench for blk_check_arbiter: directed packets push expected verdicts,
// a negedge monitor pops and compares every rpt_valid strobe.
module tb_blk_check_arbiter;

    localparam int N          = 4;
    localparam int DW         = 32;
    localparam int TB_TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [8*N-1:0]  src_data;
    logic [N-1:0]    src_last;
    logic            rpt_valid;
    logic [1:0]      rpt_src;
    logic            rpt_ok;
    logic [DW-1:0]   rpt_depth;
    logic            rpt_timeout;
    logic            busy;

    logic            v_arr [N];
    logic [7:0]      d_arr [N];
    logic            l_arr [N];

    typedef struct {
        int   src;
        logic ok;
        int   depth;
        logic tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   last_hs_cyc [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar gi = 0; gi < N; gi++) begin : g_drv
        assign src_valid[gi]          = v_arr[gi];
        assign src_data[8*gi+7:8*gi]  = d_arr[gi];
        assign src_last[gi]           = l_arr[gi];
    end

    blk_check_arbiter #(
        .N_SRC  (N),
        .DEPTH_W(DW),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .src_last   (src_last),
        .rpt_valid  (rpt_valid),
        .rpt_src    (rpt_src),
        .rpt_ok     (rpt_ok),
        .rpt_depth  (rpt_depth),
        .rpt_timeout(rpt_timeout),
        .busy       (busy)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_rpt(input int s, input logic ok, input int depth, input logic tmo);
        exp_t e;
        e.src   = s;
        e.ok    = ok;
        e.depth = depth;
        e.tmo   = tmo;
        exp_q.push_back(e);
    endtask

    // Drives one string on source s; returns how many cycles the first char waited for ready.
    task automatic send(input int s, input string str, input bit do_last, output int first_wait);
        first_wait = -1;
        for (int k = 0; k < str.len(); k++) begin
            int n;
            n = 0;
            v_arr[s] = 1'b1;
            d_arr[s] = str[k];
            l_arr[s] = do_last && (k == str.len() - 1);
            @(negedge clk);
            while (!src_ready[s]) begin
                n++;
                if (n > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_wait: src %0d char %0d got no ready in %0d cycles", s, k, n);
                    v_arr[s] = 1'b0;
                    l_arr[s] = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            if (k == 0) first_wait = n;
            if (l_arr[s]) last_hs_cyc[s] = cyc_cnt;
            @(posedge clk);
            #1;
        end
        v_arr[s] = 1'b0;
        l_arr[s] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy=%0d pending=%0d after %0d cycles", busy, exp_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per verdict strobe, checks ready is one-hot.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (|src_ready) chk("ready_onehot", $countones(src_ready), 1);
            if (rpt_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rpt: got report from src %0d, expected none", rpt_src);
                end else begin
                    e = exp_q.pop_front();
                    $display("rpt src=%0d ok=%0d depth=%0d timeout=%0d (exp src=%0d ok=%0d depth=%0d timeout=%0d)",
                             rpt_src, rpt_ok, $signed(rpt_depth), rpt_timeout, e.src, e.ok, e.depth, e.tmo);
                    chk("rpt_src", rpt_src, e.src);
                    chk("rpt_ok", rpt_ok, e.ok);
                    chk("rpt_depth", $signed(rpt_depth), e.depth);
                    chk("rpt_timeout", rpt_timeout, e.tmo);
                    if (!e.tmo) chk("rpt_latency", cyc_cnt, last_hs_cyc[e.src] + 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int fw, fw0, fw1, fw2, fw3;
        for (int i = 0; i < N; i++) begin
            v_arr[i]       = 1'b0;
            d_arr[i]       = 8'h00;
            l_arr[i]       = 1'b0;
            last_hs_cyc[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rpt_valid", rpt_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_src_ready", src_ready, 0);
        chk("reset_rpt_ok", rpt_ok, 0);
        chk("reset_rpt_depth", rpt_depth, 0);
        chk("reset_rpt_timeout", rpt_timeout, 0);
        chk("reset_rpt_src", rpt_src, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Balanced packet, also measures request-to-ready latency from IDLE.
        expect_rpt(0, 1'b1, 0, 1'b0);
        send(0, "begin end", 1'b1, fw);
        chk("req_latency", fw, 2);

        expect_rpt(1, 1'b0, 1, 1'b0);
        send(1, "end begin", 1'b1, fw);

        // Case folding, long words and empty words.
        expect_rpt(2, 1'b1, 0, 1'b0);
        send(2, "BEGIN beginx  End", 1'b1, fw);
        expect_rpt(2, 1'b0, 1, 1'b0);
        send(2, "begin begin end", 1'b1, fw);

        // Leaves rr_ptr wrapped to 0.
        expect_rpt(3, 1'b1, 0, 1'b0);
        send(3, "begin end", 1'b1, fw);
        wait_idle();

        // All four request together: served 0,1,2,3.
        expect_rpt(0, 1'b0, 0, 1'b0);
        expect_rpt(1, 1'b1, 0, 1'b0);
        expect_rpt(2, 1'b0, 0, 1'b0);
        expect_rpt(3, 1'b1, 0, 1'b0);
        fork
            send(0, "end", 1'b1, fw0);
            send(1, "abc", 1'b1, fw1);
            send(2, "ENd", 1'b1, fw2);
            send(3, "x y", 1'b1, fw3);
        join
        wait_idle();

        expect_rpt(1, 1'b0, 0, 1'b0);
        send(1, "end", 1'b1, fw);
        wait_idle();

        // Reset in the middle of a packet: no verdict, then a clean resend.
        send(2, "begin ", 1'b0, fw);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_rpt_valid", rpt_valid, 0);
        @(posedge clk);
        #1;
        expect_rpt(2, 1'b1, 0, 1'b0);
        send(2, "begin end", 1'b1, fw);
        wait_idle();

`ifdef CHK_TIMEOUT_EN
        expect_rpt(3, 1'b0, 0, 1'b1);
        send(3, "beg", 1'b0, fw);
        wait_idle();
`endif

        wait_idle();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
